// File: rtl/bitrev_reorder_stream.sv
// Streaming reorder buffer: accepts FFT samples in bit-reversed order and emits natural order.
// Optional framing check enabled with `define BITREV_FRAME_CHECK_EN (adds in_last / frame_err).
module bitrev_reorder_stream #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
`ifdef BITREV_FRAME_CHECK_EN
  input  logic         in_last,
  output logic         frame_err,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [N-1:0] out_index,
  output logic         out_last
);

  localparam int unsigned SIZE     = 1 << N;
  localparam logic [N-1:0] LAST_IDX = N'(SIZE - 1);

  function automatic logic [N-1:0] rev(input logic [N-1:0] x);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      r[i] = x[int'(N) - 1 - i];
    end
    return r;
  endfunction

  logic [1:0]   full_q, full_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [N-1:0] wr_cnt_q, wr_cnt_d;
  logic [N-1:0] rd_cnt_q, rd_cnt_d;
  logic [W-1:0] bank_q [2][SIZE];
  logic [W-1:0] bank_d [2][SIZE];
  logic         wr_acc;
  logic         rd_xfer;
`ifdef BITREV_FRAME_CHECK_EN
  logic         frame_err_q, frame_err_d;
`endif

  // All outputs decode registered state only
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_data  = bank_q[rd_bank_q][rd_cnt_q];
  assign out_index = rd_cnt_q;
  assign out_last  = full_q[rd_bank_q] & (rd_cnt_q == LAST_IDX);
`ifdef BITREV_FRAME_CHECK_EN
  assign frame_err = frame_err_q;
`endif

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    bank_d    = bank_q;
    wr_acc    = in_valid & ~full_q[wr_bank_q];
    rd_xfer   = full_q[rd_bank_q] & out_ready;
`ifdef BITREV_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif

    if (rd_xfer) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end

    // Writer only targets a non-full bank, so it never collides with the clear above
    if (wr_acc) begin
`ifdef BITREV_FRAME_CHECK_EN
      if (in_last && (wr_cnt_q != LAST_IDX)) begin
        frame_err_d = 1'b1;
        wr_cnt_d    = '0;
      end else begin
        frame_err_d = (wr_cnt_q == LAST_IDX) && !in_last;
`endif
        bank_d[wr_bank_q][rev(wr_cnt_q)] = in_data;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == LAST_IDX) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end
`ifdef BITREV_FRAME_CHECK_EN
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
`ifdef BITREV_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
`ifdef BITREV_FRAME_CHECK_EN
      frame_err_q <= frame_err_d;
`endif
    end
  end

  // Sample storage is not reset; validity is tracked by full_q alone
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_bitrev_reorder_stream.sv
// Directed self-checking bench for bitrev_reorder_stream (N=3, W=32).
module tb_bitrev_reorder_stream;

  localparam int unsigned N = 3;
  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [N-1:0] out_index;
  logic         out_last;
`ifdef BITREV_FRAME_CHECK_EN
  logic         in_last;
  logic         frame_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bitrev_reorder_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef BITREV_FRAME_CHECK_EN
    .in_last   (in_last),
    .frame_err (frame_err),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] rv(input logic [2:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef BITREV_FRAME_CHECK_EN
    in_last   = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef BITREV_FRAME_CHECK_EN
    in_last   = 1'b0;
`endif
    #2;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++;
    if (out_index !== 3'd0) begin n_err++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
    n_cmp++;
    if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", out_last); end
`ifdef BITREV_FRAME_CHECK_EN
    n_cmp++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int unsigned vals [8];
    vals = '{100, 104, 102, 106, 101, 105, 103, 107};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(vals[k]);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid k=%0d: got %b want 0", k, out_valid); end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== W'(100 + i) || out_index !== 3'(i) || out_last !== (i == 7)) begin
        n_err++;
        $display("FAIL single_out i=%0d: got v=%b d=%0d idx=%0d last=%b want v=1 d=%0d idx=%0d last=%b",
                 i, out_valid, out_data, out_index, out_last, 100 + i, i, (i == 7));
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_after: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int s;
    apply_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      in_valid = (c < 24);
      s = (c < 24) ? c : 0;
      in_data = W'(200 + (s / 8) * 8 + int'(rv(3'(s % 8))));
      if (c < 24) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready c=%0d: got %b want 1", c, in_ready); end
      end
      n_cmp++;
      if (c < 8) begin
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_fill c=%0d: out_valid got %b want 0", c, out_valid); end
      end else if (out_valid !== 1'b1 || out_data !== W'(200 + c - 8) || out_index !== 3'((c - 8) % 8)
                   || out_last !== ((c - 8) % 8 == 7)) begin
        n_err++;
        $display("FAIL b2b_out c=%0d: got v=%b d=%0d idx=%0d last=%b want v=1 d=%0d idx=%0d",
                 c, out_valid, out_data, out_index, out_last, 200 + c - 8, (c - 8) % 8);
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_after: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int acc;
    apply_reset();
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data  = W'(300 + (k / 8) * 8 + int'(rv(3'(k % 8))));
      if (k == 16) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_17th_ready: got %b want 0", in_ready); end
      end
      if (in_ready === 1'b1) acc++;
      tick();
    end
    n_cmp++;
    if (acc != 16) begin n_err++; $display("FAIL bp_accepts: got %0d want 16", acc); end
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'(300 + j) || out_index !== 3'(j)) begin
        n_err++;
        $display("FAIL bp_drain0 j=%0d: got rdy=%b v=%b d=%0d idx=%0d want rdy=0 v=1 d=%0d idx=%0d",
                 j, in_ready, out_valid, out_data, out_index, 300 + j, j);
      end
      tick();
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== W'(308 + j) || out_index !== 3'(j)) begin
        n_err++;
        $display("FAIL bp_drain1 j=%0d: got v=%b d=%0d idx=%0d want v=1 d=%0d idx=%0d",
                 j, out_valid, out_data, out_index, 308 + j, j);
      end
      tick();
      in_valid = 1'b0;
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_partial_hidden: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_random_ready();
    int sent;
    int rcv;
    apply_reset();
    sent = 0;
    rcv  = 0;
    for (int cyc = 0; cyc < 3000 && rcv < 80; cyc++) begin
      in_data   = W'(400 + (sent / 8) * 8 + int'(rv(3'(sent % 8))));
      in_valid  = (sent < 80) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (out_data !== W'(400 + rcv) || out_index !== 3'(rcv % 8) || out_last !== (rcv % 8 == 7)) begin
          n_err++;
          $display("FAIL rand_out n=%0d: got d=%0d idx=%0d last=%b want d=%0d idx=%0d",
                   rcv, out_data, out_index, out_last, 400 + rcv, rcv % 8);
        end
        rcv++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (rcv != 80 || sent != 80) begin n_err++; $display("FAIL rand_count: got rcv=%0d sent=%0d want 80/80", rcv, sent); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rand_leftover: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) begin
      in_valid = 1'b1;
      in_data  = W'(600 + k);
      if (k == 8) out_ready = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_index !== 3'd5) begin
      n_err++; $display("FAIL mid_pre_reset: got v=%b idx=%0d want v=1 idx=5", out_valid, out_index);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 3'd0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_reset: got v=%b rdy=%b idx=%0d last=%b want 0 1 0 0", out_valid, in_ready, out_index, out_last);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(700 + int'(rv(3'(k))));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== W'(700 + i) || out_index !== 3'(i)) begin
        n_err++;
        $display("FAIL mid_fresh i=%0d: got v=%b d=%0d idx=%0d want v=1 d=%0d idx=%0d", i, out_valid, out_data, out_index, 700 + i, i);
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_after: out_valid got %b want 0", out_valid); end
  endtask

`ifdef BITREV_FRAME_CHECK_EN
  task automatic test_frame_check();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = W'(800 + int'(rv(3'(k))));
      in_last  = (k == 3);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (frame_err !== 1'b1) begin n_err++; $display("FAIL fc_early_last_err: got %b want 1", frame_err); end
    tick();
    n_cmp++;
    if (frame_err !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL fc_pulse_end: got err=%b v=%b want 0 0", frame_err, out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = W'(900 + int'(rv(3'(k))));
      in_last  = (k == 7);
      tick();
      n_cmp++;
      if (frame_err !== 1'b0) begin n_err++; $display("FAIL fc_good_err k=%0d: got %b want 0", k, frame_err); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== W'(900 + i) || out_index !== 3'(i)) begin
        n_err++;
        $display("FAIL fc_out i=%0d: got v=%b d=%0d idx=%0d want v=1 d=%0d idx=%0d", i, out_valid, out_data, out_index, 900 + i, i);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_random_ready();
    test_reset_mid_frame();
`ifdef BITREV_FRAME_CHECK_EN
    test_frame_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitrev_reorder_stream.md
Name: bitrev_reorder_stream

Overview:
Streaming reorder buffer for FFT output. It accepts one sample per cycle in bit-reversed index order and emits samples in natural index order. It is the sequential inverse of the combinational bit-reverse mapper and sits between the last butterfly stage and the downstream consumer. Ping-pong banks sustain full throughput across back-to-back frames.

Parameters:
N, 3, log2 of frame size; SIZE = 2**N points per frame
W, 32, sample width in bits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input sample valid
in_ready  out  1  buffer can accept a sample
in_data  in  W  k-th sample of frame, carries index rev(k)
out_valid  out  1  output sample valid
out_ready  in  1  consumer accepts output
out_data  out  W  sample at natural index out_index
out_index  out  N  natural index of out_data, 0..SIZE-1
out_last  out  1  high with out_index == SIZE-1

Behaviour:
- Storage: two banks of SIZE x W registers; full[1:0] flags; wr_bank, wr_cnt[N-1:0]; rd_bank, rd_cnt[N-1:0].
- Reset (async, rst_n=0): full=0, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0. Outputs: in_ready=1, out_valid=0, out_index=0, out_last=0. out_data is don't-care and bank contents are not cleared.
- Reset mid-frame discards all partial and full frames.
- Write side: in_ready = !full[wr_bank]. Accept occurs when in_valid & in_ready.
- On accept: bank[wr_bank][rev(wr_cnt)] <= in_data; wr_cnt++.
- On the accept with wr_cnt == SIZE-1: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- rev(x) reverses the N bits of x. Example for N=3: 1->4, 3->6.
- Read side: out_valid = full[rd_bank]; out_data = bank[rd_bank][rd_cnt]; out_index = rd_cnt; out_last = out_valid & (rd_cnt == SIZE-1).
- On transfer (out_valid & out_ready): rd_cnt++.
- On the transfer with rd_cnt == SIZE-1: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- All outputs derive from registers only. There is no combinational path from in_* or out_ready to any output.
- Latency: out_valid rises the cycle after the frame's last input is accepted.
- Throughput: with out_ready held at 1, one sample per cycle sustained indefinitely, with no bubbles at frame boundaries.
- Both banks full: in_ready=0 until the reader frees the bank at wr_bank. in_ready rises the cycle after the freeing transfer.
- Simultaneous set and clear of the same bank cannot occur: the writer only targets a non-full bank.
- in_data is ignored when in_valid=0. Holding in_valid with in_ready=0 has no effect.

Optional Feature:
Macro BITREV_FRAME_CHECK_EN.
- Defined: adds ports in_last (in, 1) and frame_err (out, 1, reset 0, registered one-cycle pulse).
- in_last accepted with wr_cnt != SIZE-1: frame_err pulses, the partial frame is discarded (wr_cnt <= 0, full unchanged), and that sample is dropped.
- Accept at wr_cnt == SIZE-1 with in_last=0: frame_err pulses and the frame is still committed.
- Undefined: ports absent; frame boundaries come from the count alone.

Test Plan:
- Single frame, N=3, out_ready=1: inputs 100,104,102,106,101,105,103,107 -> outputs 100..107 in order, out_index 0..7, out_last only on 107, first out_valid the cycle after the 8th accept.
- Back-to-back: 24 consecutive inputs (3 frames), out_ready=1 -> in_ready stays 1 and 24 consecutive out_valid cycles with no gaps; each frame is naturally ordered.
- Backpressure: out_ready=0, drive 17 inputs -> 16 accepted, in_ready=0 at the 17th. Set out_ready=1 -> in_ready returns the cycle after out_last of frame 0 transfers.
- Random out_ready (50%) over 10 frames -> output sequence matches the model and no sample is lost or duplicated.
- rst_n low after 5 inputs of frame 1 while frame 0 is draining -> out_valid=0 immediately; a fresh frame then produces the correct order starting at out_index 0.
- BITREV_FRAME_CHECK_EN: in_last on the 4th sample -> frame_err pulse and no output. The next 8 samples with in_last on the 8th -> correct frame and frame_err stays 0.
